// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one slow, multi-cycle RAM between the instruction-fetch
// port (0) and the load/store port (1).
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | RAM deselected at RELEASE_ADDR; pick a requester, latch its access
// ACCESS  | latched access held on the RAM until ack or the timeout limit
// RELEASE | one-cycle gap at RELEASE_ADDR so the RAM stability count restarts
//
// Each access is latched when it is granted, so the RAM sees a constant
// address/data for the whole ACCESS state whatever the ports do meanwhile.
// The forced RELEASE gap makes back-to-back accesses to the same address
// look like two separate accesses to the RAM.
module ram_arbiter #(
    parameter int                ADDR_W       = 32,
    parameter int                TIMEOUT      = 64,
    parameter logic [ADDR_W-1:0] RELEASE_ADDR = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] wdata0,
    input  logic [ADDR_W-1:0] wdata1,
    output logic [ADDR_W-1:0] rdata0,
    output logic [ADDR_W-1:0] rdata1,
    output logic              ready0,
    output logic              ready1,
    output logic              err0,
    output logic              err1,
    output logic              stall0,
    output logic              stall1,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] mem_din,
    input  logic [ADDR_W-1:0] mem_dout,
    input  logic              mem_ack
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              last_grant;
    logic              grant_port;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [ADDR_W-1:0] lat_wdata;
    logic [CNT_W-1:0]  cnt;

    logic              start;
    logic              start_port;
    logic              done;
    logic              done_err;
    logic [ADDR_W-1:0] done_rdata;

    // Next state, grant choice, completion decode and RAM-side drive.
    always_comb begin
        state_nx   = state;
        start      = 1'b0;
        start_port = 1'b0;
        done       = 1'b0;
        done_err   = 1'b0;
        done_rdata = '0;
        mem_cs     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = RELEASE_ADDR;
        mem_din    = '0;
        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    start = 1'b1;
                    // on a tie the port that did not win last time goes next
                    start_port = (req0 & req1) ? ~last_grant : req1;
                    state_nx   = ACCESS;
                end
            end
            ACCESS: begin
                mem_cs   = 1'b1;
                mem_we   = lat_we;
                mem_addr = lat_addr;
                mem_din  = lat_wdata;
                // an ack in the final allowed cycle still counts as success
                if (mem_ack) begin
                    done       = 1'b1;
                    done_rdata = lat_we ? '0 : mem_dout;
                    state_nx   = RELEASE;
                end else if (cnt == CNT_LAST) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                    state_nx = RELEASE;
                end
            end
            RELEASE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Grant bookkeeping, latched access and the ACCESS cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= 1'b1;
            grant_port <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            cnt        <= '0;
        end else if (start) begin
            last_grant <= start_port;
            grant_port <= start_port;
            lat_we     <= start_port ? we1    : we0;
            lat_addr   <= start_port ? addr1  : addr0;
            lat_wdata  <= start_port ? wdata1 : wdata0;
            cnt        <= '0;
        end else if (state == ACCESS) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Completion pulses and per-port read-data capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready0 <= 1'b0;
            ready1 <= 1'b0;
            err0   <= 1'b0;
            err1   <= 1'b0;
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            ready0 <= done & ~grant_port;
            ready1 <= done & grant_port;
            err0   <= done_err & ~grant_port;
            err1   <= done_err & grant_port;
            if (done & ~grant_port) rdata0 <= done_rdata;
            if (done & grant_port)  rdata1 <= done_rdata;
        end
    end

    assign stall0 = req0 & ~ready0;
    assign stall1 = req1 & ~ready1;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed steps followed by randomized request rounds,
// checked against a transaction-level model of the arbiter's rules and a
// shadow copy of RAM contents.
module tb_ram_arbiter;

    localparam int          TO  = 16;
    localparam logic [31:0] REL = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_v = 2'b00;
    logic [1:0]  we_v = 2'b00;
    logic [31:0] addr_v [2];
    logic [31:0] wdata_v [2];

    wire  [31:0] rdata0, rdata1;
    wire         ready0, ready1, err0, err1, stall0, stall1;
    wire         mem_cs, mem_we;
    wire  [31:0] mem_addr, mem_din, mem_dout;
    wire         mem_ack;

    wire  [1:0]  ready_v = {ready1, ready0};
    wire  [1:0]  err_v   = {err1, err0};
    wire  [1:0]  stall_v = {stall1, stall0};
    wire  [31:0] rdata_v [2];
    assign rdata_v[0] = rdata0;
    assign rdata_v[1] = rdata1;

    ram_arbiter #(.ADDR_W(32), .TIMEOUT(TO), .RELEASE_ADDR(REL)) dut (
        .clk(clk), .rst(rst),
        .req0(req_v[0]), .req1(req_v[1]),
        .we0(we_v[0]), .we1(we_v[1]),
        .addr0(addr_v[0]), .addr1(addr_v[1]),
        .wdata0(wdata_v[0]), .wdata1(wdata_v[1]),
        .rdata0(rdata0), .rdata1(rdata1),
        .ready0(ready0), .ready1(ready1),
        .err0(err0), .err1(err1),
        .stall0(stall0), .stall1(stall1),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (i == 3) ? 32'hDEAD_BEEF : (32'hA5A5_0000 + 32'(i));
    endfunction

    // Slow RAM: acks once the address has been held with cs high for ack_dly cycles.
    logic [31:0] ram [16];
    logic [31:0] prev_addr = '0;
    int          stab = 0;
    int          ack_dly = 8;
    bit          ack_en = 1'b1;
    assign mem_ack  = mem_cs && ack_en && (stab >= ack_dly - 1);
    assign mem_dout = (mem_addr < 32'd16) ? ram[mem_addr[3:0]] : 32'h0;

    // RAM storage, reload on reset, and stability counter.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) ram[i] <= init_word(i);
        end else if (mem_cs && mem_we && mem_ack) begin
            ram[mem_addr[3:0]] <= mem_din;
        end
        if (mem_cs && (stab == 0 || mem_addr == prev_addr)) stab <= stab + 1;
        else if (mem_cs)                                     stab <= 1;
        else                                                 stab <= 0;
        prev_addr <= mem_addr;
    end

    // Reference state: shadow memory and the last granted port.
    logic [31:0] ref_mem [16];
    int          exp_last = 1;
    int          checks = 0;
    int          failures = 0;

    logic [31:0] t_addr [2];
    logic [31:0] t_wdata [2];
    logic        t_we [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reload_ref();
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    endtask

    // Waits (bounded) for port p's ready; checks latency, stall while waiting,
    // and that the other port never pulses ready meanwhile. Optionally scrambles
    // port p's inputs once its access has been granted.
    task automatic wait_ready(input int p, input int exp_lat, input int scr_from,
                              input string tag);
        int lat = 0;
        bit stall_ok = 1'b1;
        bit other_ok = 1'b1;
        do begin
            tick();
            lat++;
            if (ready_v[p] !== 1'b1) begin
                if (stall_v[p] !== 1'b1) stall_ok = 1'b0;
                if (scr_from > 0 && lat >= scr_from) begin
                    addr_v[p]  = $urandom;
                    wdata_v[p] = $urandom;
                    we_v[p]    = 1'($urandom_range(0, 1));
                end
            end
            if (ready_v[1-p] !== 1'b0) other_ok = 1'b0;
        end while (ready_v[p] !== 1'b1 && lat < 80);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_stall_wait"}, {31'b0, stall_ok}, 32'd1);
        chk({tag, "_other_ready"}, {31'b0, other_ok}, 32'd1);
    endtask

    // One round: the selected ports raise req together in IDLE with t_* values;
    // each served port drops req on its ready. Ends back in IDLE.
    task automatic round(input bit u0, input bit u1, input int dly, input bit en,
                         input string tag);
        int          order[$];
        int          k;
        int          p;
        bit          ok_ack;
        logic [31:0] exp_rd;
        ack_dly = dly;
        ack_en  = en;
        ok_ack  = en && (dly <= TO);
        k       = ok_ack ? dly : TO;
        for (int i = 0; i < 2; i++) begin
            addr_v[i]  = t_addr[i];
            wdata_v[i] = t_wdata[i];
            we_v[i]    = t_we[i];
        end
        req_v = {u1, u0};
        if (u0 && u1) begin
            p = (exp_last == 0) ? 1 : 0;
            order = '{p, 1 - p};
        end else begin
            order = '{u0 ? 0 : 1};
        end
        #1;
        chk({tag, "_stall_req"}, {30'b0, stall_v}, {30'b0, u1, u0});
        for (int s = 0; s < order.size(); s++) begin
            p = order[s];
            wait_ready(p, (s == 0) ? k + 1 : k + 2, (s == 0) ? 2 : 3, tag);
            exp_rd = (!ok_ack || t_we[p]) ? 32'h0 : ref_mem[t_addr[p][3:0]];
            chk({tag, "_rdata"}, rdata_v[p], exp_rd);
            chk({tag, "_err"}, {31'b0, err_v[p]}, {31'b0, !ok_ack});
            chk({tag, "_rel_cs"}, {31'b0, mem_cs}, 32'd0);
            chk({tag, "_rel_addr"}, mem_addr, REL);
            chk({tag, "_stall_done"}, {31'b0, stall_v[p]}, 32'd0);
            req_v[p] = 1'b0;
            exp_last = p;
            if (ok_ack && t_we[p]) ref_mem[t_addr[p][3:0]] = t_wdata[p];
        end
        tick();
        chk({tag, "_idle_ready"}, {30'b0, ready_v}, 32'd0);
        chk({tag, "_idle_addr"}, mem_addr, REL);
    endtask

    task automatic set_t(input int p, input logic [31:0] a, input logic w, input logic [31:0] d);
        t_addr[p]  = a;
        t_we[p]    = w;
        t_wdata[p] = d;
    endtask

    initial begin
        addr_v[0] = '0; addr_v[1] = '0; wdata_v[0] = '0; wdata_v[1] = '0;
        set_t(0, 0, 0, 0);
        set_t(1, 0, 0, 0);
        reload_ref();

        // reset state
        tick();
        tick();
        chk("rst_cs", {31'b0, mem_cs}, 32'd0);
        chk("rst_we", {31'b0, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, REL);
        chk("rst_din", mem_din, 32'd0);
        chk("rst_ready", {30'b0, ready_v}, 32'd0);
        chk("rst_err", {30'b0, err_v}, 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // single read of word 3, RAM acks on its 8th stable cycle
        set_t(0, 32'd3, 1'b0, 32'h0);
        round(1'b1, 1'b0, 8, 1'b1, "single_read");
        chk("single_read_value", rdata0, 32'hDEAD_BEEF);

        // write then read back on port 1
        set_t(1, 32'd5, 1'b1, 32'h1234_5678);
        round(1'b0, 1'b1, 8, 1'b1, "write5");
        set_t(1, 32'd5, 1'b0, 32'h0);
        round(1'b0, 1'b1, 8, 1'b1, "read5");
        chk("read5_value", rdata1, 32'h1234_5678);

        // same address twice with req0 held through ready
        ack_dly = 8;
        ack_en  = 1'b1;
        addr_v[0] = 32'd2;
        we_v[0]   = 1'b0;
        req_v[0]  = 1'b1;
        wait_ready(0, 9, 0, "b2b_first");
        chk("b2b_first_data", rdata0, ref_mem[2]);
        wait_ready(0, 10, 0, "b2b_second");
        chk("b2b_second_data", rdata0, ref_mem[2]);
        req_v[0] = 1'b0;
        exp_last = 0;
        tick();

        // timeout: RAM never acks
        set_t(1, 32'd7, 1'b0, 32'h0);
        round(1'b0, 1'b1, 8, 1'b0, "timeout");
        // ack arriving on the last allowed cycle beats the timeout
        set_t(0, 32'd9, 1'b0, 32'h0);
        round(1'b1, 1'b0, TO, 1'b1, "ack_at_limit");

        // asynchronous reset on ACCESS cycle 4
        ack_dly = 8;
        ack_en  = 1'b1;
        addr_v[0] = 32'd4;
        we_v[0]   = 1'b0;
        req_v[0]  = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("arst_cs_before", {31'b0, mem_cs}, 32'd1);
        rst = 1'b0;
        #1;
        chk("arst_cs", {31'b0, mem_cs}, 32'd0);
        chk("arst_addr", mem_addr, REL);
        req_v[0] = 1'b0;
        tick();
        tick();
        chk("arst_ready", {30'b0, ready_v}, 32'd0);
        chk("arst_err", {30'b0, err_v}, 32'd0);
        reload_ref();
        exp_last = 1;
        @(negedge clk);
        rst = 1'b1;
        tick();

        // contention from reset: expected order 0, 1, then 0 again
        set_t(0, 32'd1, 1'b0, 32'h0);
        set_t(1, 32'd6, 1'b0, 32'h0);
        round(1'b1, 1'b1, 5, 1'b1, "contend_a");
        chk("contend_a_last", 32'(exp_last), 32'd1);
        set_t(0, 32'd8, 1'b1, 32'hCAFE_0008);
        set_t(1, 32'd8, 1'b0, 32'h0);
        round(1'b1, 1'b1, 3, 1'b1, "contend_b");

        // randomized rounds
        for (int r = 0; r < 40; r++) begin
            int pat;
            int dly;
            pat = $urandom_range(1, 3);
            dly = $urandom_range(1, TO + 4);
            for (int i = 0; i < 2; i++)
                set_t(i, 32'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom);
            round(pat[0], pat[1], dly, ($urandom_range(0, 7) != 0), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-port arbiter that shares one slow, multi-cycle data RAM between the instruction-fetch port (port 0) and the load/store port (port 1).
- The RAM acknowledges an access only after its address has been held stable for several cycles.
- The arbiter sequences each access: it holds the request stable until ack, hands back the read data, then forces a release gap so the RAM's stability counter restarts.
- It sits between the CPU pipeline's memory stages and the RAM, and produces per-port stall signals.

Parameters:
- ADDR_W, 32, width of address and data buses.
- TIMEOUT, 64, maximum ACCESS cycles before the access is aborted.
- RELEASE_ADDR, 32'hFFFF_FFFF, address driven during the release gap; must map outside the RAM.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req0 / req1  in  1  access request, port 0 / port 1; held high until the port's ready.
- we0 / we1  in  1  write enable, per port.
- addr0 / addr1  in  32  word address, per port.
- wdata0 / wdata1  in  32  write data, per port.
- rdata0 / rdata1  out  32  read data, valid while the port's ready is high.
- ready0 / ready1  out  1  one-cycle completion pulse, per port.
- err0 / err1  out  1  one-cycle timeout pulse, coincident with ready.
- stall0 / stall1  out  1  combinational: reqN & ~readyN.
- mem_cs  out  1  RAM chip select.
- mem_we  out  1  RAM write enable.
- mem_addr  out  32  RAM address.
- mem_din  out  32  RAM write data.
- mem_dout  in  32  RAM read data.
- mem_ack  in  1  RAM acknowledge; stays high while the address is unchanged after completion.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; last_grant=1, so port 0 wins the first tie.
  - timeout counter=0.
  - All outputs 0, except mem_addr=RELEASE_ADDR.
- States: IDLE, ACCESS, RELEASE.
- IDLE:
  - mem_cs=0, mem_we=0, mem_addr=RELEASE_ADDR.
  - If exactly one req is high, grant that port.
  - If both are high, grant the port != last_grant.
  - On grant, latch that port's addr/we/wdata into internal registers, set last_grant, clear the counter, go to ACCESS.
- ACCESS:
  - mem_cs=1; mem_addr/mem_we/mem_din driven from the latched registers, held constant for the whole state.
  - Port inputs changing during ACCESS have no effect.
  - The counter increments each cycle.
  - If mem_ack=1: register rdataG=mem_dout (0 for writes), readyG=1, go to RELEASE.
  - Else if counter==TIMEOUT-1: rdataG=0, readyG=1, errG=1, go to RELEASE.
  - If ack and timeout occur in the same cycle, ack wins and err stays 0.
- RELEASE (exactly 1 cycle):
  - mem_cs=0, mem_we=0, mem_addr=RELEASE_ADDR; mem_ack is ignored.
  - ready/err are high during this cycle only; rdata holds its value until that port's next completion.
  - Next state is IDLE.
- Requester rule:
  - A port must drop req, or present a new request, in the cycle after ready.
  - A req still high in IDLE is treated as a new access. Back-to-back accesses to the same address are legal because RELEASE changes the address.
- Latency:
  - Single requester, RAM acking on its k-th ACCESS cycle: ready is asserted k+1 cycles after req is sampled.
  - Minimum turnaround between grants is 3 cycles (IDLE, ACCESS≥1, RELEASE).
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1.
- Reset mid-ACCESS aborts without ready or err; the RAM sees cs=0 immediately.
- stall outputs are purely combinational from req and ready; no registered path.

Test Plan:
- Single read: RAM model acks after 8 stable cycles; req0=1, addr0=3, RAM word3=32'hDEAD_BEEF → ready0 pulses on cycle 9 after grant with rdata0=32'hDEAD_BEEF; stall0 high for 9 cycles; mem_cs low in RELEASE.
- Write then read back: port1 writes 32'h1234_5678 to addr 5 → ready1, err1=0; then port1 reads addr 5 → rdata1=32'h1234_5678; mem_addr equals RELEASE_ADDR between the two accesses.
- Contention: req0 and req1 both high from reset → grant order is port0, port1, port0; each ready is a single pulse; the port that is not granted keeps stall high.
- Same-address back-to-back: port0 reads addr 2 twice with req held high → two distinct ready0 pulses, each preceded by a fresh 8-cycle wait.
- Timeout: RAM never acks, TIMEOUT=16 → on the 16th ACCESS cycle ready1=1, err1=1, rdata1=0; state returns to IDLE.
- Async reset mid-ACCESS: pull rst low on ACCESS cycle 4 → mem_cs=0 immediately with no ready pulse; after release, port0 wins the first grant.
